serial_traffic_injector: RTL

- Rate-controlled packet generator that drives one node's serial injection link (data/busy) into its router's local port.
- Transmitter-side counterpart of the throughput-counting serial_sink: it generates sequence-numbered packets, buffers them, serialises them onto the link, and counts sent and dropped packets.
- Used in the 16-node mesh bench to produce repeatable load.

---
 rtl/serial_traffic_injector.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_traffic_injector.sv
// Rate-controlled packet generator for one node's serial injection link.
// Generates sequence-numbered packets on a programmable interval, buffers
// them in a small queue and serialises each as start bit + payload (LSB
// first) + one idle cycle, counting sent frames and dropped packets.
module serial_traffic_injector #(
    parameter int          NODE_ID   = 0,
    parameter int          SIZE      = 4,
    parameter int          SEQ_BITS  = 8,
    parameter int          MODE      = 0,
    parameter int          DEST      = 1,
    parameter int          QDEPTH    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      data,
    input  logic                      busy,
    input  logic                      enable,
    input  logic [7:0]                period,
    output logic [25:0]               sent_count,
    output logic [15:0]               drop_count,
    output logic [$clog2(QDEPTH):0]   q_level
);

    localparam int PB = 2*SIZE + SEQ_BITS;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(PB);
    localparam logic [SIZE-1:0] NODE       = SIZE'(NODE_ID);
    localparam logic [SIZE-1:0] FIXED_DEST = SIZE'(DEST);
    localparam logic [CW-1:0]   LAST_BIT   = CW'(PB - 1);
    localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          timer;
    logic [SEQ_BITS-1:0] seq;
    logic [15:0]         lfsr;
    logic [SIZE-1:0]     rr_ptr;
    logic [SIZE-1:0]     rr_ptr_next;
    logic [SIZE-1:0]     lfsr_dest;
    logic [SIZE-1:0]     dest;
    logic [PB-1:0]       packet;
    logic [PB-1:0]       queue_mem [QDEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [PB-1:0]       shreg;
    logic [CW-1:0]       bit_cnt;
    logic                gen;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                data_next;
    logic                load;
    logic                shift;
    logic                done;

    // A packet is generated on the cycle the interval timer reaches period-1.
    assign gen  = enable && (period != 8'd0) && (timer >= (period - 8'd1));
    assign full = (q_level == FULL_LEVEL);
    // The transmitter only pulls a packet while idle and the receiver is free.
    assign pop  = (state == IDLE) && (q_level != '0) && !busy;
    // A full queue still accepts a packet when the head leaves in the same cycle.
    assign push = gen && (!full || pop);
    assign drop = gen && full && !pop;

    assign packet = {seq, NODE, dest};

    // Destination choice for the packet being generated this cycle.
    always_comb begin
        rr_ptr_next = rr_ptr + SIZE'(1);
        if (rr_ptr_next == NODE) begin
            rr_ptr_next = rr_ptr_next + SIZE'(1);
        end
        lfsr_dest = lfsr[SIZE-1:0];
        if (lfsr_dest == NODE) begin
            lfsr_dest = lfsr_dest ^ SIZE'(1);
        end
        case (MODE)
            1:       dest = rr_ptr;
            2:       dest = lfsr_dest;
            default: dest = FIXED_DEST;
        endcase
    end

    // Interval timer, sequence number, destination state and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer      <= 8'd0;
            seq        <= '0;
            lfsr       <= LFSR_SEED;
            rr_ptr     <= NODE + SIZE'(1);
            drop_count <= 16'd0;
        end else begin
            if (!enable || (period == 8'd0) || gen) begin
                timer <= 8'd0;
            end else begin
                timer <= timer + 8'd1;
            end
            if (gen) begin
                seq    <= seq + SEQ_BITS'(1);
                lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rr_ptr <= rr_ptr_next;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= packet;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   q_level <= q_level + (AW+1)'(1);
                2'b01:   q_level <= q_level - (AW+1)'(1);
                default: q_level <= q_level;
            endcase
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transmit FSM outputs: next line value and datapath controls.
    always_comb begin
        data_next = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    data_next = 1'b1;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                data_next = shreg[0];
                shift     = 1'b1;
                done      = (bit_cnt == LAST_BIT);
            end
            default: data_next = 1'b0;
        endcase
    end

    // Serialiser datapath and sent-frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            sent_count <= 26'd0;
        end else begin
            data <= data_next;
            if (load) begin
                shreg   <= queue_mem[rd_ptr];
                bit_cnt <= '0;
            end else if (shift) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (done) begin
                sent_count <= sent_count + 26'd1;
            end
        end
    end

endmodule
